// File: rtl/count_checker.sv
// Monitor for a free-running up-counter bus: locks onto a +1 sequence and
// reports sequence breaks, wrap-arounds and a stalled counter.
module count_checker #(
    parameter int WIDTH       = 4,
    parameter int LOCK_CNT    = 2,
    parameter int STUCK_LIMIT = 8,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             seq_err,
    output logic             wrap_pulse,
    output logic             stuck,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int SW = $clog2(STUCK_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, STUCK} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_inc;
    logic [GW-1:0]    good_run;
    logic [GW-1:0]    good_nxt;
    logic [SW-1:0]    stall_cnt;
    logic [SW-1:0]    stall_nxt;
    logic             seq_nxt;
    logic             wrap_nxt;
    logic             inc;
    logic             rep;

    assign prev_inc = prev + WIDTH'(1);
    assign inc      = (count_in == prev_inc);
    assign rep      = (count_in == prev);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_run;
        stall_nxt = stall_cnt;
        seq_nxt   = 1'b0;
        wrap_nxt  = 1'b0;
        if (en) begin
            unique case (state)
                IDLE: begin
                    state_nxt = ACQ;
                    good_nxt  = '0;
                end
                ACQ: begin
                    if (inc) begin
                        if (good_run == GW'(LOCK_CNT - 1)) begin
                            state_nxt = LOCKED;
                            good_nxt  = GW'(LOCK_CNT);
                            stall_nxt = '0;
                        end else begin
                            good_nxt = good_run + GW'(1);
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (inc) begin
                        stall_nxt = '0;
                        wrap_nxt  = &prev;
                    end else if (rep) begin
                        if (stall_cnt == SW'(STUCK_LIMIT - 1)) begin
                            state_nxt = STUCK;
                            stall_nxt = SW'(STUCK_LIMIT);
                        end else begin
                            stall_nxt = stall_cnt + SW'(1);
                        end
                    end else begin
                        seq_nxt   = 1'b1;
                        state_nxt = ACQ;
                        good_nxt  = '0;
                    end
                end
                STUCK: begin
                    // Leaving a stall never counts as a sequence error.
                    if (inc) begin
                        if (LOCK_CNT == 1) begin
                            state_nxt = LOCKED;
                            good_nxt  = GW'(1);
                            stall_nxt = '0;
                        end else begin
                            state_nxt = ACQ;
                            good_nxt  = GW'(1);
                        end
                    end else if (!rep) begin
                        state_nxt = ACQ;
                        good_nxt  = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prev       <= '0;
            good_run   <= '0;
            stall_cnt  <= '0;
            seq_err    <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            good_run   <= good_nxt;
            stall_cnt  <= stall_nxt;
            seq_err    <= seq_nxt;
            wrap_pulse <= wrap_nxt;
            if (en) begin
                prev <= count_in;
            end
            if (clr_err) begin
                err_count <= '0;
            end else if (seq_nxt && !(&err_count)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    assign locked = (state == LOCKED);
    assign stuck  = (state == STUCK);

endmodule

// File: tb/tb_count_checker.sv
// Table-driven bench for count_checker with an expected-value queue.
module tb_count_checker;

    typedef logic [11:0] obs_t;

    typedef struct {
        logic       en;
        logic [3:0] cin;
        logic       clr;
        obs_t       exp;
        string      nm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] count_in = '0;
    logic       clr_err = 1'b0;
    logic       locked;
    logic       seq_err;
    logic       wrap_pulse;
    logic       stuck;
    logic [7:0] err_count;

    int   n_vec  = 0;
    int   n_miss = 0;
    obs_t sbq[$];
    vec_t tbl[$];

    count_checker #(
        .WIDTH(4), .LOCK_CNT(2), .STUCK_LIMIT(8), .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in),
        .clr_err(clr_err), .locked(locked), .seq_err(seq_err),
        .wrap_pulse(wrap_pulse), .stuck(stuck), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic obs_t ob(bit lk, bit se, bit wp, bit sk, int ec);
        return {lk, se, wp, sk, 8'(ec)};
    endfunction

    function automatic vec_t mk(bit e, int c, bit cl, obs_t x, string nm);
        vec_t v;
        v.en  = e;
        v.cin = 4'(c);
        v.clr = cl;
        v.exp = x;
        v.nm  = nm;
        return v;
    endfunction

    task automatic check_now(input obs_t want, input string nm);
        obs_t got;
        got = {locked, seq_err, wrap_pulse, stuck, err_count};
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        obs_t got;
        obs_t want;
        @(negedge clk);
        en       = v.en;
        count_in = v.cin;
        clr_err  = v.clr;
        sbq.push_back(v.exp);
        @(posedge clk);
        #1;
        got  = {locked, seq_err, wrap_pulse, stuck, err_count};
        want = sbq.pop_front();
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", v.nm, got, want);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] p;
        logic [3:0] b;
        int         ec;

        tbl.push_back(mk(1, 0, 0, ob(0,0,0,0,0), "lock0"));
        tbl.push_back(mk(1, 1, 0, ob(0,0,0,0,0), "lock1"));
        tbl.push_back(mk(1, 2, 0, ob(1,0,0,0,0), "lock2"));
        for (int i = 3; i <= 5; i++)
            tbl.push_back(mk(1, i, 0, ob(1,0,0,0,0), "run"));
        tbl.push_back(mk(1, 9, 0, ob(0,1,0,0,1), "brk9"));
        tbl.push_back(mk(1, 10, 0, ob(0,0,0,0,1), "brk10"));
        tbl.push_back(mk(1, 11, 0, ob(1,0,0,0,1), "brk11"));
        for (int i = 12; i <= 15; i++)
            tbl.push_back(mk(1, i, 0, ob(1,0,0,0,1), "prewrap"));
        tbl.push_back(mk(1, 0, 0, ob(1,0,1,0,1), "wrap0"));
        tbl.push_back(mk(1, 1, 0, ob(1,0,0,0,1), "wrap1"));
        for (int i = 2; i <= 7; i++)
            tbl.push_back(mk(1, i, 0, ob(1,0,0,0,1), "run2"));
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(1, 7, 0, ob(1,0,0,0,1), "rep"));
        tbl.push_back(mk(1, 7, 0, ob(0,0,0,1,1), "stuck8"));
        tbl.push_back(mk(1, 7, 0, ob(0,0,0,1,1), "stuck9"));
        tbl.push_back(mk(1, 8, 0, ob(0,0,0,0,1), "unstk8"));
        tbl.push_back(mk(1, 9, 0, ob(1,0,0,0,1), "relk9"));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, (i * 3) % 16, 0, ob(1,0,0,0,1), "en0"));
        tbl.push_back(mk(1, 10, 0, ob(1,0,0,0,1), "after_en0"));

        #3;
        check_now(ob(0,0,0,0,0), "reset");
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        p = 4'd10;
        for (int i = 0; i < 300; i++) begin
            ec = (i + 2 > 255) ? 255 : i + 2;
            b  = p + 4'd5;
            apply(mk(1, b, 0, ob(0,1,0,0,ec), "sat_brk"));
            apply(mk(1, b + 4'd1, 0, ob(0,0,0,0,ec), "sat_acq"));
            apply(mk(1, b + 4'd2, 0, ob(1,0,0,0,ec), "sat_lock"));
            p = b + 4'd2;
        end

        b = p + 4'd5;
        apply(mk(1, b, 1, ob(0,1,0,0,0), "clr_brk"));
        apply(mk(1, b + 4'd1, 0, ob(0,0,0,0,0), "clr_acq"));
        apply(mk(1, b + 4'd2, 0, ob(1,0,0,0,0), "clr_lock"));
        p = b + 4'd2;
        b = p + 4'd5;
        apply(mk(1, b, 0, ob(0,1,0,0,1), "pre_rst_brk"));
        apply(mk(1, b + 4'd1, 0, ob(0,0,0,0,1), "pre_rst_acq"));
        apply(mk(1, b + 4'd2, 0, ob(1,0,0,0,1), "pre_rst_lock"));

        #2;
        rst = 1'b0;
        #1;
        check_now(ob(0,0,0,0,0), "async_rst");
        @(negedge clk);
        rst = 1'b1;
        apply(mk(1, 3, 0, ob(0,0,0,0,0), "post_rst3"));
        apply(mk(1, 4, 0, ob(0,0,0,0,0), "post_rst4"));
        apply(mk(1, 5, 0, ob(1,0,0,0,0), "post_rst5"));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/count_checker.md
# count_checker

Sequence checker that sits at the consuming end of a free-running WIDTH-bit up-counter bus. It samples the count every enabled clock, locks onto a valid +1 (mod 2^WIDTH) sequence, and flags sequence breaks, wrap-arounds and a stalled counter. It is used as an on-chip or bench-side monitor for counter blocks, for example the 4-bit counter.

## Interface
- WIDTH, 4: width of the observed count.
- LOCK_CNT, 2: consecutive good increments required to declare lock (≥1).
- STUCK_LIMIT, 8: consecutive repeated samples while locked that declare the counter stuck (≥1).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count_in is sampled on this edge when 1.
- count_in  input  WIDTH  observed counter value.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  level; sequence is being tracked.
- seq_err  output  1  one-cycle pulse on a sequence break while locked.
- wrap_pulse  output  1  one-cycle pulse when a locked sample wraps from all-ones to 0.
- stuck  output  1  level; the counter has stalled.
- err_count  output  ERR_W  number of seq_err events, saturating.

## Operation
- Internal state:
  - prev: last sampled value.
  - good_run: increment run length, 0..LOCK_CNT.
  - stall_cnt: repeat run length, 0..STUCK_LIMIT.
  - FSM with states IDLE, ACQ, LOCKED, STUCK.
- An "increment" means count_in == prev + 1, computed in WIDTH bits so it wraps. A "repeat" means count_in == prev.
- prev is loaded with count_in on every sample taken with en=1, in all states.
- IDLE: on the first sample, go to ACQ with good_run=0.
- ACQ:
  - On an increment, good_run+1. When good_run reaches LOCK_CNT, go to LOCKED with stall_cnt=0.
  - On any other value, good_run=0. No error is flagged.
- LOCKED:
  - Increment: stall_cnt=0. If prev is all-ones (the new value is 0), pulse wrap_pulse.
  - Repeat: stall_cnt+1. When it reaches STUCK_LIMIT, go to STUCK.
  - Any other value: pulse seq_err, err_count+1 (saturating at all-ones), go to ACQ with good_run=0.
- STUCK:
  - A repeat keeps the block in STUCK.
  - An increment goes to ACQ with good_run=1; if LOCK_CNT=1, it goes directly to LOCKED.
  - Any other value goes to ACQ with good_run=0. No seq_err is flagged on exit from STUCK.
- Output decode: locked=1 only in LOCKED, stuck=1 only in STUCK.
- en=0: no state, counter or prev change. Pulses are 0.
- clr_err: err_count becomes 0 on that edge. It takes priority over a simultaneous increment.

## Timing
- All outputs are registered and update on the same rising edge that samples count_in, so latency is 1 clock from sample to output.
- seq_err and wrap_pulse are high for exactly one cycle per event. They are never both high.
- On reset assertion, without waiting for a clock edge: state=IDLE, prev=0, good_run=0, stall_cnt=0, locked=0, stuck=0, seq_err=0, wrap_pulse=0, err_count=0.
- Reset mid-operation discards lock. After release, the first sample behaves as from IDLE.
- Reset release is assumed synchronous to clk by the integrator. The block adds no synchronizer.

## Test plan
Defaults apply: WIDTH=4, LOCK_CNT=2, STUCK_LIMIT=8, ERR_W=8.
- Lock-on: release rst, en=1, count_in 0,1,2 -> locked=1 after the edge sampling 2, seq_err=0, err_count=0.
- Wrap: while locked, feed 14,15,0,1 -> wrap_pulse high exactly for the cycle after sampling 0, locked stays 1, seq_err=0.
- Break: while locked at 5, feed 9,10,11 -> seq_err pulse after 9, err_count=1, locked=0, then locked=1 after 11.
- Stall: while locked, feed 7 then 7 eight more times -> stuck=1 and locked=0 after the 8th repeat. Then feed 8,9 -> stuck=0 after 8, locked=1 after 9, err_count unchanged.
- Saturation/clear: force 300 breaks -> err_count holds 255. Assert clr_err on the same edge as a break -> err_count=0 and seq_err still pulses. With en=0 for 10 cycles -> no output change.
- Async reset: while locked, drive rst low between edges -> all outputs 0 immediately. After release, 3,4,5 -> relock.
